// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling, frame error and break handling.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [7:0] shift;
  logic rx_m, rx_s;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end
  // Outputs pulse for one cycle: cleared every cycle unless set by the STOP decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          cnt <= cnt == MID ? '0 : cnt + 1'b1;
          if (cnt == MID) begin
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            shift[idx[2:0]] <= rx_s;
            idx <= idx + 1'b1;
            if (idx == 4'd7) state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            if (rx_s) data <= shift;
            valid <= rx_s;
            frame_err <= !rx_s;
            state <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames, glitch, framing error/break, mid-frame reset and baud tolerance.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_HZ = 16000000;
  localparam int BAUD = 115200;
  localparam int CPB = CLK_HZ / BAUD;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int errs = 0, checks = 0, vcnt = 0, fcnt = 0, both = 0;
  int v0, f0;
  logic [7:0] got[$];
  logic [7:0] msg[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
  logic [7:0] a5 = 8'hA5;
  always #5 clk = ~clk;
  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      got.push_back(data);
    end
    if (frame_err) fcnt++;
    if (valid && frame_err) both++;
  end
  task check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask
  task send(input logic [7:0] b, input logic stop, input int per);
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop, per);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, CPB);
    v0 = vcnt;
    send(8'h48, 1'b1, CPB);
    hold(1'b1, 2 * CPB);
    check("h_count", vcnt - v0, 1);
    check("h_data", got[v0], 8'h48);
    check("h_ferr", fcnt, 0);
    check("h_busy", busy, 1'b0);
    v0 = vcnt;
    for (int i = 0; i < 13; i++) send(msg[i], 1'b1, CPB);
    hold(1'b1, 2 * CPB);
    check("hello_count", vcnt - v0, 13);
    for (int i = 0; i < 13; i++) check($sformatf("hello_byte%0d", i), got[v0 + i], msg[i]);
    check("hello_ferr", fcnt, 0);
    v0 = vcnt;
    hold(1'b0, 10);
    @(negedge clk);
    check("glitch_busy_hi", busy, 1'b1);
    hold(1'b0, CPB / 4 - 10);
    hold(1'b1, 2 * CPB);
    check("glitch_valid", vcnt - v0, 0);
    check("glitch_ferr", fcnt, 0);
    check("glitch_busy_lo", busy, 1'b0);
    v0 = vcnt;
    f0 = fcnt;
    send(8'h55, 1'b0, CPB);
    hold(1'b0, 20 * CPB);
    @(negedge clk);
    check("brk_ferr_once", fcnt - f0, 1);
    check("brk_valid", vcnt - v0, 0);
    check("brk_data_kept", data, 8'h0A);
    check("brk_busy", busy, 1'b1);
    hold(1'b1, 5);
    @(negedge clk);
    check("brk_exit", busy, 1'b0);
    hold(1'b1, CPB);
    check("brk_ferr_final", fcnt - f0, 1);
    v0 = vcnt;
    f0 = fcnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(a5[i], CPB);
    hold(a5[4], CPB / 2);
    #3;
    rst = 1'b1;
    rx = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_data", data, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, CPB);
    check("arst_no_out", vcnt - v0, 0);
    send(8'h3C, 1'b1, CPB);
    hold(1'b1, 2 * CPB);
    check("arst_count", vcnt - v0, 1);
    check("arst_data_3c", data, 8'h3C);
    check("arst_ferr", fcnt - f0, 0);
    v0 = vcnt;
    send(8'h00, 1'b1, CPB * 102 / 100);
    send(8'hFF, 1'b1, CPB * 102 / 100);
    send(8'h00, 1'b1, CPB * 98 / 100);
    send(8'hFF, 1'b1, CPB * 98 / 100);
    hold(1'b1, 2 * CPB);
    check("tol_count", vcnt - v0, 4);
    check("tol_slow_00", got[v0], 8'h00);
    check("tol_slow_ff", got[v0 + 1], 8'hFF);
    check("tol_fast_00", got[v0 + 2], 8'h00);
    check("tol_fast_ff", got[v0 + 3], 8'hFF);
    check("tol_ferr", fcnt - f0, 0);
    check("never_both", both, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, 50000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, 115200, line bit rate.
REQ-003 The block SHALL derive local constant CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division; 434 at defaults).
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port data  output  8  last correctly framed byte.
REQ-008 The block SHALL have port valid  output  1  one-cycle pulse when data updates.
REQ-009 The block SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx_s==0 -> START, bit counter cleared to 0.
REQ-015 START: when counter reaches CLKS_PER_BIT/2-1, rx_s==0 -> DATA (counter and bit index cleared); rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: each time counter reaches CLKS_PER_BIT-1, rx_s SHALL be stored in shift bit [index], counter cleared, index incremented; after index 7 is sampled -> STOP.
REQ-017 STOP: when counter reaches CLKS_PER_BIT-1, rx_s==1 -> data <= shift register, valid=1 for exactly one cycle, -> IDLE.
REQ-018 STOP with rx_s==0 -> frame_err=1 for exactly one cycle, data unchanged, -> BREAK.
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; a held-low line SHALL produce exactly one frame_err.
REQ-020 valid and frame_err SHALL never be high in the same cycle.
REQ-021 data SHALL hold its value between valid pulses; no downstream handshake, consumer must capture on valid.
REQ-022 Back-to-back frames (start bit immediately after stop sample) SHALL be received without loss.
REQ-023 Counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; index width 3 bits plus terminal detect; no wrap-around inside a bit period.
REQ-024 Latency: valid SHALL assert CLKS_PER_BIT*9.5 + 3 cycles (+/-1) after the falling edge of rx at the pin.

Reset
REQ-025 On rst high, immediately and asynchronously: state=IDLE, counter=0, index=0, shift=0x00, data=0x00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err; after release the block SHALL wait for the next falling edge in IDLE.
REQ-027 Reset release SHALL need no clock-domain precondition beyond one clk edge; a low rx at release SHALL be treated as a start bit.

Verification (defaults, 434 clks/bit)
REQ-028 Drive 0x48 ('H') 8N1 -> one valid pulse, data=0x48, frame_err never high, busy low after.
REQ-029 Send "Hello World!\n" back-to-back with no idle gap -> 13 valid pulses, bytes in order, no frame_err.
REQ-030 Pull rx low for 100 cycles then high -> START aborts at sample point, no valid, no frame_err, busy returns low.
REQ-031 Send 0x55 with stop bit forced 0, then hold rx low for 20 bit times -> exactly one frame_err, data keeps previous value, state stays BREAK until rx high.
REQ-032 Assert rst during data bit 4 of 0xA5, release, then send 0x3C -> no output for 0xA5, data=0x3C with single valid.
REQ-033 Send 0x00 and 0xFF at BAUD +/-2% bit period -> both received correctly.
